ascon_perm_ctrl: RTL and testbench

- Round scheduler for the Ascon permutation datapath: constant addition, 64-sbox substitution layer, linear diffusion, 320-bit state register.
- Accepts a permutation request (p12, p8 or p6) through a ready/valid handshake.
- Drives the datapath one round per cycle: state-register enable, init/feedback mux select, round index and round constant.
- Holds the result valid until the consumer acknowledges it.
- Sits between the Ascon mode FSM (init/AD/PT/final phases) and the permutation datapath.

---
 rtl/ascon_perm_ctrl.sv | 144 ++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ascon_perm_ctrl
// Description : Round scheduler for the Ascon permutation datapath. It accepts
//               p12/p8/p6 requests and drives one round per cycle. The result
//               is then held valid until the consumer acknowledges it.
//               Optional feature: define ASCON_PERM_ABORT_EN to add abort_i.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_perm_ctrl #(
  parameter int MAX_ROUNDS = 12,
  parameter int CNT_W      = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  output logic             ready_o,
  output logic             sel_init_o,
  output logic             en_state_o,
  output logic [CNT_W-1:0] round_o,
  output logic [7:0]       const_o,
  output logic             valid_o,
  input  logic             ack_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_IDX  = CNT_W'(MAX_ROUNDS - 1);
  localparam logic [CNT_W-1:0] C_START_P12 = CNT_W'(MAX_ROUNDS - 12);
  localparam logic [CNT_W-1:0] C_START_P8  = CNT_W'(MAX_ROUNDS - 8);
  localparam logic [CNT_W-1:0] C_START_P6  = CNT_W'(MAX_ROUNDS - 6);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_start;
  logic             w_mode_ok;
  logic             w_abort;
  logic [CNT_W-1:0] w_start_idx;
  logic [3:0]       w_r_lo;

  // Start is masked while reset is held so the enable stays low asynchronously.
  assign w_start = start_i & ~reset_i;

`ifdef ASCON_PERM_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_mode_ok   = 1'b1;
    w_start_idx = C_START_P12;
    case (mode_i)
      2'b00:   w_start_idx = C_START_P12;
      2'b01:   w_start_idx = C_START_P8;
      2'b10:   w_start_idx = C_START_P6;
      default: w_mode_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_o    = 1'b0;
    sel_init_o = 1'b0;
    en_state_o = 1'b0;
    round_o    = cnt_q;
    valid_o    = 1'b0;
    busy_o     = 1'b0;
    err_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (w_start) begin
          if (w_mode_ok) begin
            // The first round runs in the accept cycle on the external state.
            sel_init_o = 1'b1;
            en_state_o = 1'b1;
            round_o    = w_start_idx;
            cnt_d      = w_start_idx + CNT_W'(1);
            state_d    = S_RUN;
          end else begin
            err_o = 1'b1;
          end
        end
      end

      S_RUN: begin
        busy_o = 1'b1;
        if (w_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          en_state_o = 1'b1;
          if (cnt_q == C_LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        valid_o = ~w_abort;
        if (w_abort || ack_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_r_lo  = 4'(round_o);
  assign const_o = {4'd15 - w_r_lo, w_r_lo};

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_perm_ctrl
// Description : Self-checking bench for ascon_perm_ctrl: table of permutation
//               requests with a round scoreboard, plus handwritten corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_perm_ctrl;

  logic       clock_i;
  logic       reset_i;
  logic       start_i;
  logic [1:0] mode_i;
  logic       ready_o;
  logic       sel_init_o;
  logic       en_state_o;
  logic [3:0] round_o;
  logic [7:0] const_o;
  logic       valid_o;
  logic       ack_i;
  logic       busy_o;
  logic       err_o;
`ifdef ASCON_PERM_ABORT_EN
  logic       abort_i;
`endif

  ascon_perm_ctrl #(.MAX_ROUNDS(12), .CNT_W(4)) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .ready_o    (ready_o),
    .sel_init_o (sel_init_o),
    .en_state_o (en_state_o),
    .round_o    (round_o),
    .const_o    (const_o),
    .valid_o    (valid_o),
    .ack_i      (ack_i),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i    (abort_i),
`endif
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  typedef struct {
    logic [1:0] mode;
    int         s;
    int         n;
    int         c0;
    bit         noise;
  } vec_t;

  typedef struct {
    int r;
    int c;
    int sel;
  } exp_t;

  vec_t tbl[3];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rc(input int r);
    return ((15 - r) << 4) | r;
  endfunction

  // Accept a request, follow the rounds against the scoreboard, stop in DONE.
  task automatic do_perm(input logic [1:0] mode, input int s, input int n,
                         input int c0, input bit noise);
    int cyc;
    exp_t e;
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = mode;
    for (int r = s; r < 12; r++) sb.push_back('{r, rc(r), (r == s) ? 1 : 0});
    #1;
    chk("accept_ready", int'(ready_o), 1);
    chk("first_const", int'(const_o), c0);
    cyc = 0;
    while (sb.size() > 0 && cyc < 30) begin
      if (en_state_o) begin
        e = sb.pop_front();
        chk("round", int'(round_o), e.r);
        chk("const", int'(const_o), e.c);
        chk("sel_init", int'(sel_init_o), e.sel);
        chk("busy", int'(busy_o), (cyc == 0) ? 0 : 1);
        chk("err_quiet", int'(err_o), 0);
      end else begin
        chk("en_state_run", int'(en_state_o), 1);
      end
      @(negedge clock_i);
      start_i = noise && (sb.size() > 0);
      mode_i  = noise ? 2'b11 : mode;
      ack_i   = noise && (sb.size() > 0);
      #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      chk("round_timeout", sb.size(), 0);
      sb.delete();
    end
    start_i = 1'b0;
    ack_i   = 1'b0;
    #1;
    chk("latency", cyc, n);
    chk("done_valid", int'(valid_o), 1);
    chk("done_en", int'(en_state_o), 0);
    chk("done_busy", int'(busy_o), 0);
    chk("done_ready", int'(ready_o), 0);
  endtask

  task automatic do_ack();
    @(negedge clock_i);
    ack_i = 1'b1;
    #1;
    chk("ack_valid", int'(valid_o), 1);
    @(negedge clock_i);
    ack_i = 1'b0;
    #1;
    chk("ack_ready", int'(ready_o), 1);
    chk("ack_valid_low", int'(valid_o), 0);
    chk("ack_round0", int'(round_o), 0);
  endtask

  // Start a p12 and stop once the given round is executing.
  task automatic run_to_round(input int target);
    int guard;
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 2'b00;
    #1;
    guard = 0;
    while (int'(round_o) != target && guard < 30) begin
      @(negedge clock_i);
      start_i = 1'b0;
      #1;
      guard++;
    end
    start_i = 1'b0;
    chk("reach_round", int'(round_o), target);
  endtask

  initial begin
    bit stuck;
    reset_i = 1'b1;
    start_i = 1'b0;
    mode_i  = 2'b00;
    ack_i   = 1'b0;
`ifdef ASCON_PERM_ABORT_EN
    abort_i = 1'b0;
`endif
    tbl[0] = '{2'b00, 0, 12, 8'hF0, 1'b0};
    tbl[1] = '{2'b01, 4, 8,  8'hB4, 1'b1};
    tbl[2] = '{2'b10, 6, 6,  8'h96, 1'b0};

    #2;
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_en", int'(en_state_o), 0);
    chk("rst_round", int'(round_o), 0);
    chk("rst_const", int'(const_o), 8'hF0);
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;

    for (int i = 0; i < 3; i++) begin
      do_perm(tbl[i].mode, tbl[i].s, tbl[i].n, tbl[i].c0, tbl[i].noise);
      chk("last_const", int'(rc(11)), 8'h4B);
      if (i == 2) begin
        stuck = 1'b1;
        repeat (20) begin
          @(negedge clock_i);
          #1;
          if (!valid_o || en_state_o) stuck = 1'b0;
        end
        chk("hold_valid", int'(stuck), 1);
      end
      do_ack();
    end

    // Illegal mode: single-cycle error, no acceptance.
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 2'b11;
    #1;
    chk("ill_err", int'(err_o), 1);
    chk("ill_en", int'(en_state_o), 0);
    chk("ill_ready", int'(ready_o), 1);
    @(negedge clock_i);
    start_i = 1'b0;
    #1;
    chk("ill_err_pulse", int'(err_o), 0);
    chk("ill_ready_after", int'(ready_o), 1);
    chk("ill_busy", int'(busy_o), 0);
    do_perm(2'b01, 4, 8, 8'hB4, 1'b0);
    do_ack();

    // Asynchronous reset in the middle of round 5.
    run_to_round(5);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_ready", int'(ready_o), 1);
    chk("mid_rst_en", int'(en_state_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_round", int'(round_o), 0);
    chk("mid_rst_const", int'(const_o), 8'hF0);
    @(negedge clock_i);
    reset_i = 1'b0;
    do_perm(2'b01, 4, 8, 8'hB4, 1'b0);
    do_ack();

`ifdef ASCON_PERM_ABORT_EN
    run_to_round(3);
    abort_i = 1'b1;
    #1;
    chk("abort_en", int'(en_state_o), 0);
    @(negedge clock_i);
    abort_i = 1'b0;
    #1;
    chk("abort_ready", int'(ready_o), 1);
    stuck = 1'b0;
    repeat (14) begin
      @(negedge clock_i);
      #1;
      if (valid_o) stuck = 1'b1;
    end
    chk("abort_no_valid", int'(stuck), 0);
    do_perm(2'b10, 6, 6, 8'h96, 1'b0);
    @(negedge clock_i);
    abort_i = 1'b1;
    ack_i   = 1'b1;
    @(negedge clock_i);
    abort_i = 1'b0;
    ack_i   = 1'b0;
    #1;
    chk("abort_done_ready", int'(ready_o), 1);
    chk("abort_done_valid", int'(valid_o), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
